card_round_ctrl: RTL and testbench

Round sequencer for the two-card bell game.
- Deals pseudo-random cards onto the checker inputs c1/n1 and c2/n2, alternating slots.
- Opens a timed response window after each deal and accepts a bell press from either player on the keypad.
- Samples the checker's match_ok verdict, keeps both players' scores and declares a winner.

---
 rtl/card_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_card_round_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_round_ctrl.sv
// card_round_ctrl: round sequencer for the two-card bell game.
// Deals LFSR-derived cards alternately into slot 1 / slot 2, opens a timed
// response window after each deal, judges the first bell press against the
// checker's match_ok verdict, keeps both scores and declares a winner.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start               level; starts a game from IDLE or OVER
//   keypad_in[3:0]      4'd1 = player 1 bell, 4'd2 = player 2 bell
//   match_ok            checker verdict for the cards on c1/n1/c2/n2
//   c1,c2[1:0] n1,n2[2:0]  card slots presented to the checker
//   card_valid          both slots hold dealt cards
//   score1,score2[3:0]  player scores
//   result[1:0]         1-cycle pulse: 01 correct, 10 wrong, 11 timeout
//   winner[1:0]         01 / 10 once a player reaches WIN_SCORE
//   busy                high outside IDLE and OVER
module card_round_ctrl #(
  parameter int         DEAL_CYCLES = 16,
  parameter int         RESP_CYCLES = 32,
  parameter int         WIN_SCORE   = 5,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] keypad_in,
  input  logic       match_ok,
  output logic [1:0] c1,
  output logic [2:0] n1,
  output logic [1:0] c2,
  output logic [2:0] n2,
  output logic       card_valid,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] result,
  output logic [1:0] winner,
  output logic       busy
);

  localparam int CNT_MAX = (DEAL_CYCLES > RESP_CYCLES) ? DEAL_CYCLES : RESP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEAL, S_WAIT, S_JUDGE, S_SCORE, S_OVER
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       lfsr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             slot2;    // next deal goes to slot 2
  logic             p2;       // latched presser is player 2
  logic             match_q;  // verdict sampled in JUDGE

  logic       key_hit, deal_last, resp_last, won;
  logic [1:0] new_col;
  logic [2:0] lo3, new_num;
  logic [3:0] cur_score, upd_score;

  assign key_hit   = (keypad_in == 4'd1) || (keypad_in == 4'd2);
  assign deal_last = cnt == CNT_W'(DEAL_CYCLES - 1);
  assign resp_last = cnt == CNT_W'(RESP_CYCLES - 1);

  // card mapping: colour 00 is illegal and folds onto 01; number in 1..5
  assign new_col = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
  assign lo3     = lfsr[4:2];
  assign new_num = ((lo3 >= 3'd5) ? (lo3 - 3'd5) : lo3) + 3'd1;

  // presser's score after judgement; decrement saturates at 0, increment
  // cannot pass WIN_SCORE because reaching it ends the game
  assign cur_score = p2 ? score2 : score1;
  assign upd_score = match_q ? (cur_score + 4'd1)
                             : ((cur_score == 4'd0) ? 4'd0 : (cur_score - 4'd1));
  assign won       = upd_score == 4'(WIN_SCORE);

  assign busy = !((state == S_IDLE) || (state == S_OVER));

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b1;
    case (state)
      S_IDLE, S_OVER: if (start) state_nxt = S_DEAL;
      S_DEAL: begin
        cnt_clr = deal_last;
        // the slot-2 write of this deal is what raises card_valid
        if (deal_last) state_nxt = (card_valid || slot2) ? S_WAIT : S_DEAL;
      end
      S_WAIT: begin
        cnt_clr = key_hit || resp_last;
        // a press on the last window cycle takes priority over timeout
        if (key_hit)        state_nxt = S_JUDGE;
        else if (resp_last) state_nxt = S_DEAL;
      end
      S_JUDGE: state_nxt = S_SCORE;
      S_SCORE: state_nxt = won ? S_OVER : S_DEAL;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      cnt        <= '0;
      slot2      <= 1'b0;
      p2         <= 1'b0;
      match_q    <= 1'b0;
      c1         <= 2'b01;
      c2         <= 2'b01;
      n1         <= 3'd1;
      n2         <= 3'd1;
      card_valid <= 1'b0;
      score1     <= 4'd0;
      score2     <= 4'd0;
      result     <= 2'b00;
      winner     <= 2'b00;
    end else begin
      // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running
      lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      state  <= state_nxt;
      cnt    <= cnt_clr ? '0 : cnt + CNT_W'(1);
      result <= 2'b00;
      case (state)
        S_IDLE, S_OVER: if (start) begin
          score1     <= 4'd0;
          score2     <= 4'd0;
          winner     <= 2'b00;
          card_valid <= 1'b0;
          slot2      <= 1'b0;
        end
        S_DEAL: if (deal_last) begin
          if (slot2) begin
            c2         <= new_col;
            n2         <= new_num;
            card_valid <= 1'b1;
          end else begin
            c1 <= new_col;
            n1 <= new_num;
          end
          slot2 <= ~slot2;
        end
        S_WAIT: begin
          if (key_hit)        p2     <= (keypad_in == 4'd2);
          else if (resp_last) result <= 2'b11;
        end
        S_JUDGE: match_q <= match_ok;
        S_SCORE: begin
          if (p2) score2 <= upd_score;
          else    score1 <= upd_score;
          result <= match_q ? 2'b01 : 2'b10;
          if (won) winner <= p2 ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_round_ctrl.sv
// Testbench for card_round_ctrl: directed rounds; expected result/score
// tuples are queued at stimulus time and popped by a monitor whenever the
// DUT pulses result. Card values are predicted from the LFSR definition.
module tb_card_round_ctrl;
  localparam int DEAL_CYCLES = 16;
  localparam int RESP_CYCLES = 32;
  localparam int WIN_SCORE   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] keypad_in = 4'd0;
  logic       match_ok = 1'b0;
  logic [1:0] c1, c2, result, winner;
  logic [2:0] n1, n2;
  logic [3:0] score1, score2;
  logic       card_valid, busy;

  card_round_ctrl #(
    .DEAL_CYCLES(DEAL_CYCLES), .RESP_CYCLES(RESP_CYCLES),
    .WIN_SCORE(WIN_SCORE), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .keypad_in(keypad_in),
    .match_ok(match_ok), .c1(c1), .n1(n1), .c2(c2), .n2(n2),
    .card_valid(card_valid), .score1(score1), .score2(score2),
    .result(result), .winner(winner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] res;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference LFSR (x^8+x^6+x^5+x^4+1), seeded on reset
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  // bench-side game state
  logic [3:0] s1 = 0, s2 = 0;
  int         ptr = 1;
  logic [1:0] ec1 = 2'b01, ec2 = 2'b01;
  logic [2:0] en1 = 3'd1, en2 = 3'd1;
  logic       ev = 1'b0;

  function automatic logic [1:0] exp_col(input logic [7:0] l);
    return (l[1:0] == 2'b00) ? 2'b01 : l[1:0];
  endfunction

  function automatic logic [2:0] exp_num(input logic [7:0] l);
    int v;
    v = int'(l[4:2]);
    return 3'((v % 5) + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && result != 2'b00) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: result=%b s1=%0d s2=%0d with nothing expected (t=%0t)",
                 result, score1, score2, $time);
      end else begin
        e = sb.pop_front();
        if ({result, score1, score2, winner} !== e) begin
          n_bad++;
          $display("FAIL sb_result: got res=%b s1=%0d s2=%0d win=%b expected res=%b s1=%0d s2=%0d win=%b (t=%0t)",
                   result, score1, score2, winner, e.res, e.s1, e.s2, e.win, $time);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, card_valid, 0);
    check({tag, "_cards"}, {c1, n1, c2, n2}, {2'b01, 3'd1, 2'b01, 3'd1});
    check({tag, "_scores"}, {score1, score2}, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  task automatic model_reset;
    s1 = 0; s2 = 0; ptr = 1; ev = 0;
    ec1 = 2'b01; ec2 = 2'b01; en1 = 3'd1; en2 = 3'd1;
  endtask

  // entry: negedge of DEAL count 0; exit: negedge just after the deal edge
  task automatic deal_step;
    logic [1:0] ec;
    logic [2:0] en;
    repeat (DEAL_CYCLES - 1) @(negedge clk);
    keypad_in = 4'd0;
    check("pre_deal_result", result, 0);
    ec = exp_col(m_lfsr);
    en = exp_num(m_lfsr);
    @(negedge clk);
    if (ptr == 1) begin ec1 = ec; en1 = en; ptr = 2; end
    else          begin ec2 = ec; en2 = en; ptr = 1; ev = 1'b1; end
    check("card1", {c1, n1}, {ec1, en1});
    check("card2", {c2, n2}, {ec2, en2});
    check("card_legal", (c1 != 2'b00) && (c2 != 2'b00) && (n1 >= 1) && (n1 <= 5)
                        && (n2 >= 1) && (n2 <= 5), 1);
    check("card_valid", card_valid, ev);
  endtask

  // entry: negedge of WAIT count 0; key is pressed at count dly
  task automatic press_round(input logic [3:0] who, input logic m, input int dly);
    exp_t       e;
    logic [3:0] ns;
    match_ok = ~m;
    repeat (dly) @(negedge clk);
    keypad_in = who;
    match_ok  = m;
    ns = (who == 4'd1) ? s1 : s2;
    if (m)              ns = ns + 4'd1;
    else if (ns != 0)   ns = ns - 4'd1;
    if (who == 4'd1) s1 = ns; else s2 = ns;
    e.res = m ? 2'b01 : 2'b10;
    e.s1  = s1;
    e.s2  = s2;
    e.win = (ns == 4'(WIN_SCORE)) ? who[1:0] : 2'b00;
    sb.push_back(e);
    @(negedge clk);               // JUDGE
    check("judge_quiet", result, 0);
    @(negedge clk);               // SCORE; verdict already sampled
    match_ok = ~m;
    check("score_quiet", result, 0);
    @(negedge clk);               // two edges after the press edge
    check("press_result", result, e.res);
    if (e.win != 2'b00) begin
      keypad_in = 4'd0;
      check("over_busy", busy, 0);
    end else begin
      check("deal_busy", busy, 1);
      deal_step();                // key stays held through DEAL: ignored
    end
  endtask

  task automatic timeout_round;
    exp_t e;
    e.res = 2'b11; e.s1 = s1; e.s2 = s2; e.win = 2'b00;
    sb.push_back(e);
    for (int i = 0; i < RESP_CYCLES; i++) begin
      keypad_in = (i % 2 == 0) ? 4'd7 : 4'd0;
      if (i == RESP_CYCLES - 1) check("timeout_quiet", result, 0);
      @(negedge clk);
    end
    check("timeout_result", result, 2'b11);
    check("timeout_scores", {score1, score2}, {s1, s2});
    keypad_in = 4'd2;
    deal_step();
  endtask

  task automatic start_game(input int hold);
    start = 1'b1;
    fork
      begin repeat (hold) @(negedge clk); start = 1'b0; end
    join_none
    @(negedge clk);
    s1 = 0; s2 = 0; ptr = 1; ev = 0;
    check("start_busy", busy, 1);
    check("start_clear", {score1, score2, winner, card_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // game 1: deal both slots, then a mix of presses and timeouts
    start_game(1);
    keypad_in = 4'd1;             // presses during DEAL are ignored
    deal_step();
    keypad_in = 4'd1;
    deal_step();
    press_round(4'd1, 1'b1, 0);   // s1 -> 1
    press_round(4'd2, 1'b0, 3);   // s2 stays 0
    press_round(4'd2, 1'b1, 1);   // s2 -> 1
    press_round(4'd2, 1'b1, 0);   // s2 -> 2
    press_round(4'd2, 1'b0, 2);   // s2 -> 1
    timeout_round();
    timeout_round();
    press_round(4'd1, 1'b1, RESP_CYCLES - 1);  // last-cycle press beats timeout
    press_round(4'd1, 1'b1, 5);   // s1 -> 3

    // async reset in WAIT with score1 = 3
    check("pre_reset_s1", score1, 3);
    #2 rst = 1'b1;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("sb_after_reset", sb.size(), 0);

    // game 2: start held high for three cycles, player 1 wins
    start_game(3);
    keypad_in = 4'd1;
    deal_step();
    deal_step();
    for (int r = 0; r < WIN_SCORE; r++) press_round(4'd1, 1'b1, r + 1);
    check("win_winner", winner, 2'b01);

    // OVER holds everything and ignores the keypad
    keypad_in = 4'd1;
    repeat (4) @(negedge clk);
    keypad_in = 4'd0;
    check("over_hold", {score1, score2, winner, busy}, {4'd5, 4'd0, 2'b01, 1'b0});
    check("over_cards", {c1, n1, c2, n2}, {ec1, en1, ec2, en2});
    check("over_result", result, 0);

    start_game(1);
    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
